// File: rtl/gcd_initiator.sv
// Requester front end for the subtractive GCD engine: valid/ready in, start/done to engine,
// valid/ready out, zero-operand bypass and WAIT watchdog. Optional stats via GCD_INIT_STATS_EN.
module gcd_initiator #(
  parameter int N       = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_res,
  output logic         out_err,
  output logic         eng_start,
  output logic [N-1:0] eng_a,
  output logic [N-1:0] eng_b,
  input  logic         eng_done,
  input  logic [N-1:0] eng_res
`ifdef GCD_INIT_STATS_EN
  ,
  output logic [15:0]  stat_ops,
  output logic [15:0]  stat_tmo
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, nxt;
  logic [N-1:0]    op_a, op_b, res_q;
  logic            err_q;
  logic [TO_W-1:0] cnt;

  logic accept, zero_op, tmo_hit, hs;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_RESP);
  assign eng_start = (state == S_ISSUE);
  assign eng_a     = op_a;
  assign eng_b     = op_b;
  assign out_res   = res_q;
  assign out_err   = err_q;

  assign accept  = in_valid && in_ready;
  assign zero_op = (in_a == '0) || (in_b == '0);
  assign tmo_hit = (cnt == TO_W'(TIMEOUT - 1));
  assign hs      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept) nxt = zero_op ? S_RESP : S_ISSUE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  if (eng_done || tmo_hit) nxt = S_RESP;
      S_RESP:  if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Result regs only move on entry to RESP, so they hold through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_a <= in_a;
          op_b <= in_b;
          if (zero_op) begin
            res_q <= in_a | in_b;
            err_q <= 1'b0;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + TO_W'(1);
          // done takes priority over a coincident timeout
          if (eng_done) begin
            res_q <= eng_res;
            err_q <= 1'b0;
          end else if (tmo_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_INIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops <= '0;
      stat_tmo <= '0;
    end else if (hs) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (err_q && stat_tmo != 16'hFFFF) stat_tmo <= stat_tmo + 16'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: doc/gcd_initiator.md
Name: gcd_initiator

Overview:
Requester-side front end for the GCD engine. Accepts operand pairs over a valid/ready input channel and issues a start pulse plus operands to the engine. Waits for the engine's done pulse, then returns the result over a valid/ready output channel. Adds a zero-operand bypass, because the subtractive engine never terminates on a zero operand, and a watchdog timeout.

Parameters:
N, 32, operand/result width
TIMEOUT, 1024, maximum WAIT cycles before abandoning an operation (>=2)
TO_W, 16, watchdog counter width (2**TO_W >= TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair
in_a  input  N  operand A
in_b  input  N  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_res  output  N  GCD result
out_err  output  1  result invalid due to timeout (qualified by out_valid)
eng_start  output  1  one-cycle start pulse to engine
eng_a  output  N  operand A to engine
eng_b  output  N  operand B to engine
eng_done  input  1  engine completion pulse
eng_res  input  N  engine result, valid with eng_done

Behaviour:
- Reset (rst high at a clk edge): state->IDLE; op regs, out_res, out_err, counter->0; out_valid=0, eng_start=0. in_ready forced to 0 while rst is high.
- States: IDLE, ISSUE, WAIT, RESP. in_ready=1 only in IDLE (rst low). out_valid=1 only in RESP.
- IDLE: on in_valid&in_ready, latch in_a/in_b.
  - If either operand is 0: out_res<=in_a|in_b (gcd(0,x)=x, gcd(0,0)=0), out_err<=0, go to RESP. No eng_start.
  - Otherwise go to ISSUE.
- ISSUE: eng_start=1 for exactly this cycle. Clear counter. Go to WAIT.
- eng_a/eng_b are driven from the latched registers and stay stable from ISSUE until the next acceptance.
- WAIT: counter increments each cycle.
  - eng_done=1: out_res<=eng_res, out_err<=0, go to RESP.
  - Else if counter==TIMEOUT-1: out_res<=0, out_err<=1, go to RESP.
  - If eng_done and the timeout coincide, done wins.
- RESP: out_valid, out_res and out_err are held stable until out_ready=1. Then go to IDLE (out_valid drops the next cycle). No new pair is accepted in the handoff cycle.
- Latency, non-zero path: accept at cycle T; eng_start at T+1; out_valid at D+1, where D is the cycle eng_done is seen.
- Latency, bypass path: out_valid at T+1.
- Throughput: at most one operation in flight.
- eng_done outside WAIT is ignored.
- Reset mid-operation: the operation is abandoned and no response is produced.
- Limitation: the engine shares rst; a stale eng_done after a timeout can be misattributed if it lands in the next WAIT.
- Widths: all result paths are N bits; no truncation.

Optional Feature:
Macro GCD_INIT_STATS_EN.
- Defined: adds outputs stat_ops (16 bits) and stat_tmo (16 bits), saturating at 16'hFFFF, cleared by rst.
  - stat_ops increments on every out_valid&out_ready handshake.
  - stat_tmo increments on every handshake with out_err=1.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. in_a=48, in_b=18; engine model pulses done 5 cycles after start with eng_res=6 -> single eng_start with eng_a=48, eng_b=18; out_res=6, out_err=0, out_valid one cycle after done.
2. in_a=0, in_b=35, then in_a=0, in_b=0 -> no eng_start; out_res=35 then 0, each valid one cycle after acceptance, out_err=0.
3. Result 6 pending, out_ready low 10 cycles, in_valid held with 7/21 -> out_valid/out_res=6 stable and in_ready=0 throughout; after handshake, 7/21 accepted and 7 returned.
4. TIMEOUT=16, engine never pulses done -> out_valid with out_err=1, out_res=0 after exactly 16 WAIT cycles; next op 9/6 returns 3.
5. rst asserted for 1 cycle in WAIT -> next cycle IDLE, out_valid=0, in_ready=1; a late eng_done is ignored; next op 12/8 returns 4.
6. TIMEOUT=16, eng_done with eng_res=5 on the 16th WAIT cycle -> out_res=5, out_err=0. With GCD_INIT_STATS_EN: stat_ops counts all handshakes, stat_tmo=1 after test 4.
